bin_to_bcd_encoder: RTL

Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method, one bit per clock. It is the producer side of the seven-segment display path: it turns a binary count into packed BCD digits, each of which feeds one per-digit seven-segment decoder. Digits set to 4'hF (blanked leading zeros, overflow) fall outside 0–9, so the decoder shows them as all segments off.

---
 rtl/bin_to_bcd_encoder_if.sv | 23 ++
 rtl/bin_to_bcd_encoder.sv | 107 ++++++++++
 2 files changed

// File: rtl/bin_to_bcd_encoder_if.sv
// Handshake bundle between a binary producer and the sequential BCD converter.
interface bin_to_bcd_encoder_if #(
   parameter int BIN_W  = 14,
   parameter int DIGITS = 4
);
   logic                  start;
   logic [BIN_W-1:0]      bin;
   logic                  blank_lz;
   logic                  busy;
   logic                  done;
   logic [4*DIGITS-1:0]   bcd;
   logic                  overflow;

   modport master (
      output start, bin, blank_lz,
      input  busy, done, bcd, overflow
   );

   modport slave (
      input  start, bin, blank_lz,
      output busy, done, bcd, overflow
   );
endinterface

// File: rtl/bin_to_bcd_encoder.sv
// Double-dabble binary-to-BCD converter, one input bit per clock, with
// overflow saturation to all-blank digits and optional leading-zero blanking.
module bin_to_bcd_encoder #(
   parameter int BIN_W  = 14,
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   bin_to_bcd_encoder_if.slave   bus
);
   localparam int SW    = 4 * DIGITS;
   localparam int CMP_W = SW + 4;
   localparam int CNT_W = $clog2(BIN_W + 1);

   function automatic logic [CMP_W-1:0] pow10(input int unsigned n);
      logic [CMP_W-1:0] p;
      p = CMP_W'(1);
      for (int unsigned i = 0; i < n; i++) p = p * CMP_W'(10);
      return p;
   endfunction

   localparam logic [CMP_W-1:0] MAX_VAL = pow10(DIGITS) - CMP_W'(1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t            state;
   logic [BIN_W-1:0]  binreg;
   logic [SW-1:0]     scratch;
   logic [CNT_W-1:0]  cnt;
   logic              ovf_flag;
   logic              blz_flag;
   logic              busy_q;
   logic              done_q;
   logic [SW-1:0]     bcd_q;
   logic              overflow_q;

   logic [SW-1:0]     adjusted;
   logic [SW-1:0]     next_scratch;
   logic [SW-1:0]     formatted;
   logic              leading;

   always_comb begin
      adjusted = scratch;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (scratch[4*i +: 4] >= 4'd5) adjusted[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
      next_scratch = (adjusted << 1) | SW'(binreg[BIN_W-1]);

      // Blank zero digits from the top until the first nonzero one; digit 0 always shows.
      formatted = next_scratch;
      leading   = blz_flag;
      for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
         if (leading && next_scratch[4*i +: 4] == 4'd0) formatted[4*i +: 4] = 4'hF;
         else leading = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         binreg     <= '0;
         scratch    <= '0;
         cnt        <= '0;
         ovf_flag   <= 1'b0;
         blz_flag   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         bcd_q      <= '0;
         overflow_q <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  binreg   <= bus.bin;
                  blz_flag <= bus.blank_lz;
                  scratch  <= '0;
                  cnt      <= CNT_W'(BIN_W);
                  ovf_flag <= (CMP_W'(bus.bin) > MAX_VAL);
                  busy_q   <= 1'b1;
                  state    <= SHIFT;
               end else begin
                  state <= IDLE;
               end
            end
            SHIFT: begin
               scratch <= next_scratch;
               binreg  <= binreg << 1;
               cnt     <= cnt - 1'b1;
               if (cnt == CNT_W'(1)) begin
                  state      <= DONE;
                  busy_q     <= 1'b0;
                  done_q     <= 1'b1;
                  overflow_q <= ovf_flag;
                  bcd_q      <= ovf_flag ? '1 : formatted;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.bcd      = bcd_q;
   assign bus.overflow = overflow_q;
endmodule
